// File: rtl/tick_gen_multi.sv
// rtl/tick_gen_multi.sv - multi-channel programmable tick and square-wave generator
// Each channel counts 0..active_div; new divisors wait in a shadow until terminal or restart.
module tick_gen_multi #(
   parameter int CHANNELS    = 4,
   parameter int WIDTH       = 16,
   parameter int DEFAULT_DIV = 326
) (
   input  logic                CLOCK_50,
   input  logic                reset,
   input  logic [CHANNELS-1:0] enable,
   input  logic                restart,
   input  logic                wr_en,
   input  logic [3:0]          wr_ch,
   input  logic [WIDTH-1:0]    wr_data,
   output logic [CHANNELS-1:0] tick,
   output logic [CHANNELS-1:0] square,
   output logic [CHANNELS-1:0] pending
);

   localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);

   logic [WIDTH-1:0]    cnt_q [CHANNELS];
   logic [WIDTH-1:0]    cnt_d [CHANNELS];
   logic [WIDTH-1:0]    act_q [CHANNELS];
   logic [WIDTH-1:0]    act_d [CHANNELS];
   logic [WIDTH-1:0]    shd_q [CHANNELS];
   logic [WIDTH-1:0]    shd_d [CHANNELS];
   logic [CHANNELS-1:0] tick_q, tick_d;
   logic [CHANNELS-1:0] square_q, square_d;
   logic [CHANNELS-1:0] pend_q, pend_d;
   logic [CHANNELS-1:0] wr_hit, term, load;
   logic [WIDTH-1:0]    new_div [CHANNELS];

   always_comb begin
      wr_hit = '0;
      term   = '0;
      load   = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         // Out-of-range channel indices never match any i, so they are dropped here.
         wr_hit[i]  = wr_en && (wr_ch == 4'(i));
         term[i]    = enable[i] && (cnt_q[i] == act_q[i]);
         load[i]    = wr_hit[i] || pend_q[i];
         new_div[i] = wr_hit[i] ? wr_data : shd_q[i];

         cnt_d[i]    = cnt_q[i];
         act_d[i]    = act_q[i];
         shd_d[i]    = shd_q[i];
         tick_d[i]   = 1'b0;
         square_d[i] = square_q[i];
         pend_d[i]   = pend_q[i];

         if (restart || term[i]) begin
            cnt_d[i]    = '0;
            tick_d[i]   = !restart;
            square_d[i] = restart ? 1'b0 : ~square_q[i];
            if (load[i]) begin
               act_d[i]  = new_div[i];
               shd_d[i]  = new_div[i];
               pend_d[i] = 1'b0;
            end
         end else begin
            if (enable[i]) begin
               cnt_d[i] = cnt_q[i] + WIDTH'(1);
            end
            if (wr_hit[i]) begin
               shd_d[i]  = wr_data;
               pend_d[i] = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < CHANNELS; i++) begin
            cnt_q[i] <= '0;
            act_q[i] <= DEF_DIV;
            shd_q[i] <= DEF_DIV;
         end
         tick_q   <= '0;
         square_q <= '0;
         pend_q   <= '0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            cnt_q[i] <= cnt_d[i];
            act_q[i] <= act_d[i];
            shd_q[i] <= shd_d[i];
         end
         tick_q   <= tick_d;
         square_q <= square_d;
         pend_q   <= pend_d;
      end
   end

   assign tick    = tick_q;
   assign square  = square_q;
   assign pending = pend_q;

endmodule

// File: tb/tb_tick_gen_multi.sv
// tb/tb_tick_gen_multi.sv - randomized bench for tick_gen_multi against a countdown reference model
module tb_tick_gen_multi;
   localparam int CH  = 4;
   localparam int W   = 16;
   localparam int DEF = 326;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [CH-1:0] en;
   logic          restart;
   logic          wr_en;
   logic [3:0]    wr_ch;
   logic [W-1:0]  wr_data;
   logic [CH-1:0] tick, square, pending;

   always #10 clk = ~clk;

   tick_gen_multi #(.CHANNELS(CH), .WIDTH(W), .DEFAULT_DIV(DEF)) dut (
      .CLOCK_50(clk), .reset(rst_n), .enable(en), .restart(restart),
      .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data),
      .tick(tick), .square(square), .pending(pending)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   // Model view: rem = edges left before the next terminal; period = act + 1.
   int m_rem [CH];
   int m_act [CH];
   int m_shd [CH];
   bit m_tk  [CH];
   bit m_sq  [CH];
   bit m_pnd [CH];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s (cycle %0d): got %0h, expected %0h", tag, cyc, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < CH; i++) begin
         m_rem[i] = DEF; m_act[i] = DEF; m_shd[i] = DEF;
         m_tk[i] = 0; m_sq[i] = 0; m_pnd[i] = 0;
      end
   endtask

   task automatic model_step();
      bit w;
      if (!rst_n) begin
         model_reset();
         return;
      end
      for (int i = 0; i < CH; i++) begin
         w = wr_en && (int'(wr_ch) == i);
         if (restart || (en[i] && m_rem[i] == 0)) begin
            if (w) begin
               m_act[i] = int'(wr_data); m_shd[i] = int'(wr_data); m_pnd[i] = 0;
            end else if (m_pnd[i]) begin
               m_act[i] = m_shd[i]; m_pnd[i] = 0;
            end
            m_rem[i] = m_act[i];
            m_tk[i]  = !restart;
            m_sq[i]  = restart ? 1'b0 : !m_sq[i];
         end else begin
            m_tk[i] = 0;
            if (en[i]) m_rem[i] = m_rem[i] - 1;
            if (w) begin
               m_shd[i] = int'(wr_data); m_pnd[i] = 1;
            end
         end
      end
   endtask

   task automatic compare_all();
      logic [CH-1:0] et, es, ep;
      for (int i = 0; i < CH; i++) begin
         et[i] = m_tk[i]; es[i] = m_sq[i]; ep[i] = m_pnd[i];
      end
      check("tick", tick, et);
      check("square", square, es);
      check("pending", pending, ep);
   endtask

   // Called at a falling edge with inputs already driven.
   task automatic step();
      model_step();
      @(posedge clk);
      #1;
      cyc++;
      compare_all();
      @(negedge clk);
   endtask

   task automatic idle();
      wr_en = 0; restart = 0; wr_ch = '0; wr_data = '0;
   endtask

   task automatic write(input int ch, input int val);
      wr_en = 1; wr_ch = 4'(ch); wr_data = W'(val);
      step();
      idle();
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic measure_first_tick(input string tag);
      int first = -1;
      for (int c = 1; c <= 700; c++) begin
         step();
         if (tick[0] && first < 0) first = c;
      end
      check(tag, first, DEF + 1);
   endtask

   initial begin
      bit found;
      rst_n = 0; en = '1; idle();
      model_reset();
      repeat (3) @(negedge clk);
      check("reset_tick", tick, '0);
      check("reset_square", square, '0);
      check("reset_pending", pending, '0);
      rst_n = 1;

      measure_first_tick("first_tick_after_reset");

      found = 0;
      for (int k = 0; k < 800 && !found; k++) begin
         if (m_act[1] - m_rem[1] == 100) found = 1; else step();
      end
      check("sync_ch1_cnt100", found, 1);
      write(1, 9);
      check("pending1_raised", pending[1], 1'b1);
      run(600);

      found = 0;
      for (int k = 0; k < 800 && !found; k++) begin
         if (m_rem[2] == 0) found = 1; else step();
      end
      check("sync_ch2_terminal", found, 1);
      write(2, 4);
      check("pending2_bypass", pending[2], 1'b0);
      run(20);

      run(60);
      en[0] = 0; run(50);
      en[0] = 1; run(400);

      write(3, 0);
      run(20);
      write(0, 7);
      write(1, 12);
      restart = 1; step(); idle();
      run(100);

      write(7, 3);
      run(30);
      rst_n = 0;
      #1;
      check("reset_async_tick", tick, '0);
      check("reset_async_square", square, '0);
      check("reset_async_pending", pending, '0);
      step();
      rst_n = 1;
      measure_first_tick("first_tick_after_midreset");

      for (int k = 0; k < 4000; k++) begin
         if ($urandom_range(99) < 5) en[$urandom_range(CH - 1)] ^= 1'b1;
         wr_en   = ($urandom_range(9) == 0);
         wr_ch   = 4'($urandom_range(7));
         wr_data = ($urandom_range(3) == 0) ? W'($urandom_range(400)) : W'($urandom_range(12));
         restart = ($urandom_range(149) == 0);
         rst_n   = ($urandom_range(1999) != 0);
         step();
      end
      idle();
      rst_n = 1;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
